// File: rtl/mont_pkg.sv
// mont_pkg: shared constants and types for the Montgomery exponent path
package mont_pkg;
  localparam int REGISTER_SIZE = 32;
  localparam int BITS_IN_N = 2048;
  localparam int BLOCKS_PER_EXP = BITS_IN_N / REGISTER_SIZE;
  typedef logic [REGISTER_SIZE-1:0] block_t;
  typedef enum logic {R_WAIT, R_STREAM} streamer_state_t;
endpackage

// File: rtl/exponent_bit_streamer.sv
// exponent_bit_streamer: ping-pong exponent buffer presenting one bit per consume pulse, LSB first
module exponent_bit_streamer #(
  parameter int REGISTER_SIZE = mont_pkg::REGISTER_SIZE,
  parameter int BITS_IN_N = mont_pkg::BITS_IN_N
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     block_valid_in,
  input  logic [REGISTER_SIZE-1:0] block_in,
  output logic                     block_ready_out,
  input  logic                     consumed_in,
  output logic                     n_bit_out,
  output logic                     n_bit_valid_out,
  output logic                     last_bit_out,
  output logic                     exp_done_out,
  output logic                     underflow_out
);
  import mont_pkg::streamer_state_t;
  import mont_pkg::R_WAIT;
  import mont_pkg::R_STREAM;
  localparam int BLOCKS = BITS_IN_N / REGISTER_SIZE;
  localparam int IW = BLOCKS > 1 ? $clog2(BLOCKS) : 1;
  localparam int BW = $clog2(REGISTER_SIZE);
  localparam int AW = $clog2(2 * BLOCKS);
  logic [REGISTER_SIZE-1:0] r_mem [2*BLOCKS];
  logic [1:0]               r_full;
  logic                     r_wbank, r_rbank;
  logic [IW-1:0]            r_widx, r_ridx;
  logic [BW-1:0]            r_rbit;
  streamer_state_t          r_state;
  logic                     r_done, r_underflow;
  logic                     w_accept, w_wlast, w_streaming, w_wrap, w_last, w_consume;
  logic [AW-1:0]            w_waddr, w_raddr;
  logic [REGISTER_SIZE-1:0] w_word;
  logic [1:0]               w_set, w_clr;
  assign block_ready_out = !r_full[r_wbank];
  assign w_accept    = block_valid_in && block_ready_out;
  assign w_wlast     = r_widx == IW'(BLOCKS - 1);
  assign w_streaming = r_state == R_STREAM;
  assign w_wrap      = r_rbit == BW'(REGISTER_SIZE - 1);
  assign w_last      = w_streaming && w_wrap && r_ridx == IW'(BLOCKS - 1);
  assign w_consume   = consumed_in && w_streaming;
  assign w_waddr     = AW'(r_wbank) * AW'(BLOCKS) + AW'(r_widx);
  assign w_raddr     = AW'(r_rbank) * AW'(BLOCKS) + AW'(r_ridx);
  assign w_word      = r_mem[w_raddr];
  assign w_set       = (w_accept && w_wlast) ? 2'b01 << r_wbank : 2'b00;
  assign w_clr       = (w_consume && w_last) ? 2'b01 << r_rbank : 2'b00;
  assign n_bit_out       = w_streaming && w_word[r_rbit];
  assign n_bit_valid_out = w_streaming;
  assign last_bit_out    = w_last;
  assign exp_done_out    = r_done;
  assign underflow_out   = r_underflow;
  // exponent storage; contents are don't-care after reset so no reset term
  always_ff @(posedge clk_in)
    if (w_accept) r_mem[w_waddr] <= block_in;
  // write pointer: fill one bank, then hop to the other
  always_ff @(posedge clk_in or posedge rst_in)
    if (rst_in) begin
      r_wbank <= 1'b0;
      r_widx  <= '0;
    end else if (w_accept) begin
      r_widx <= w_wlast ? '0 : r_widx + 1'b1;
      if (w_wlast) r_wbank <= ~r_wbank;
    end
  // bank full flags; set and clear always target different banks
  always_ff @(posedge clk_in or posedge rst_in)
    if (rst_in) r_full <= 2'b00;
    else        r_full <= (r_full | w_set) & ~w_clr;
  // read FSM: wait for a full bank, then step one bit per consume pulse
  always_ff @(posedge clk_in or posedge rst_in)
    if (rst_in) begin
      r_state     <= R_WAIT;
      r_rbank     <= 1'b0;
      r_ridx      <= '0;
      r_rbit      <= '0;
      r_done      <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_done      <= w_consume && w_last;
      r_underflow <= r_underflow | (consumed_in && !w_streaming);
      if (!w_streaming) begin
        if (r_full[r_rbank]) r_state <= R_STREAM;
      end else if (consumed_in) begin
        if (w_last) begin
          r_state <= R_WAIT;
          r_rbank <= ~r_rbank;
          r_ridx  <= '0;
          r_rbit  <= '0;
        end else if (w_wrap) begin
          r_rbit <= '0;
          r_ridx <= r_ridx + 1'b1;
        end else r_rbit <= r_rbit + 1'b1;
      end
    end
endmodule

// File: tb/tb_exponent_bit_streamer.sv
// tb_exponent_bit_streamer: directed self-checking bench for exponent_bit_streamer
module tb_exponent_bit_streamer;
  logic clk_in = 1'b0;
  logic rst_in = 1'b1;
  logic v = 1'b0, c = 1'b0;
  logic [31:0] b = '0;
  logic ready, nbit, nvalid, last, done, uf;
  logic fv = 1'b0, fc = 1'b0;
  logic [31:0] fb = '0;
  logic fready, fnbit, fnvalid, flast, fdone, fuf;
  int errors = 0, checks = 0;
  logic [63:0] va, vb, vc, vd, bits;
  int ones, lastcnt, lastidx;
  logic first;
  always #5 clk_in = ~clk_in;
  exponent_bit_streamer #(.REGISTER_SIZE(32), .BITS_IN_N(64)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .block_valid_in(v), .block_in(b),
    .block_ready_out(ready), .consumed_in(c), .n_bit_out(nbit),
    .n_bit_valid_out(nvalid), .last_bit_out(last), .exp_done_out(done),
    .underflow_out(uf)
  );
  exponent_bit_streamer dut_f (
    .clk_in(clk_in), .rst_in(rst_in), .block_valid_in(fv), .block_in(fb),
    .block_ready_out(fready), .consumed_in(fc), .n_bit_out(fnbit),
    .n_bit_valid_out(fnvalid), .last_bit_out(flast), .exp_done_out(fdone),
    .underflow_out(fuf)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask
  task automatic cyc(input logic vv, input logic [31:0] bb, input logic cc);
    v = vv; b = bb; c = cc;
    @(posedge clk_in); #1;
    v = 1'b0; c = 1'b0;
  endtask
  task automatic load(input logic [63:0] x);
    cyc(1'b1, x[31:0], 1'b0);
    cyc(1'b1, x[63:32], 1'b0);
  endtask
  task automatic stream(input string tag, input logic [63:0] exp);
    logic [63:0] got, lasts, vals;
    for (int i = 0; i < 64; i++) begin
      got[i] = nbit; lasts[i] = last; vals[i] = nvalid;
      cyc(1'b0, 32'h0, 1'b1);
    end
    chk({tag, "_bits"}, got, exp);
    chk({tag, "_last"}, lasts, 64'h8000_0000_0000_0000);
    chk({tag, "_valid"}, vals, {64{1'b1}});
    chk({tag, "_done"}, done, 1'b1);
    chk({tag, "_valid_fall"}, nvalid, 1'b0);
  endtask
  initial begin
    va = 64'h0123_4567_89AB_CDEF;
    vb = 64'hFEDC_BA98_7654_3210;
    vc = 64'hDEAD_BEEF_CAFE_F00D;
    vd = 64'h0F0F_0000_FFFF_1234;
    repeat (3) @(posedge clk_in);
    #1;
    chk("rst_ready", ready, 1'b1);
    chk("rst_valid", nvalid, 1'b0);
    chk("rst_nbit", nbit, 1'b0);
    chk("rst_last", last, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_uf", uf, 1'b0);
    rst_in = 1'b0;
    cyc(1'b0, 32'h0, 1'b0);
    // underflow with nothing loaded
    cyc(1'b0, 32'h0, 1'b1);
    chk("uf_set", uf, 1'b1);
    chk("uf_valid", nvalid, 1'b0);
    cyc(1'b0, 32'h0, 1'b0);
    chk("uf_sticky", uf, 1'b1);
    // basic stream
    load(64'h8000_0000_0000_0005);
    chk("basic_valid_t1", nvalid, 1'b0);
    chk("basic_ready", ready, 1'b1);
    cyc(1'b0, 32'h0, 1'b0);
    chk("basic_valid_t2", nvalid, 1'b1);
    chk("basic_bit0", nbit, 1'b1);
    stream("basic", 64'h8000_0000_0000_0005);
    cyc(1'b0, 32'h0, 1'b0);
    chk("basic_done_pulse", done, 1'b0);
    // ping-pong: A all ones, B all zeros, back-to-back
    load({64{1'b1}});
    load(64'h0);
    chk("pp_ready_low", ready, 1'b0);
    chk("pp_a_valid", nvalid, 1'b1);
    cyc(1'b1, 32'hDEAD_DEAD, 1'b0);
    chk("pp_ignored_ready", ready, 1'b0);
    stream("pp_a", {64{1'b1}});
    chk("pp_ready_back", ready, 1'b1);
    cyc(1'b0, 32'h0, 1'b0);
    chk("pp_b_valid", nvalid, 1'b1);
    stream("pp_b", 64'h0);
    // simultaneous final write of B and final consume of A
    load(va);
    cyc(1'b0, 32'h0, 1'b0);
    chk("sim_a_valid", nvalid, 1'b1);
    for (int i = 0; i < 64; i++) begin
      bits[i] = nbit;
      cyc(i == 20 || i == 63, i == 20 ? vb[31:0] : vb[63:32], 1'b1);
    end
    chk("sim_a_bits", bits, va);
    chk("sim_done", done, 1'b1);
    chk("sim_ready", ready, 1'b1);
    chk("sim_valid_fall", nvalid, 1'b0);
    cyc(1'b0, 32'h0, 1'b0);
    chk("sim_b_valid", nvalid, 1'b1);
    stream("sim_b", vb);
    // reset mid-stream with a partial load pending
    load(vc);
    cyc(1'b0, 32'h0, 1'b0);
    repeat (10) cyc(1'b0, 32'h0, 1'b1);
    chk("mid_bit10", nbit, vc[10]);
    cyc(1'b1, 32'h1111_1111, 1'b0);
    chk("mid_uf_before", uf, 1'b1);
    #2 rst_in = 1'b1;
    #1;
    chk("arst_valid", nvalid, 1'b0);
    chk("arst_nbit", nbit, 1'b0);
    chk("arst_last", last, 1'b0);
    chk("arst_uf", uf, 1'b0);
    chk("arst_ready", ready, 1'b1);
    @(posedge clk_in); #1;
    rst_in = 1'b0;
    load(vd);
    cyc(1'b0, 32'h0, 1'b0);
    chk("reload_valid", nvalid, 1'b1);
    stream("reload", vd);
    // full-size instance: exponent 0x1 over 2048 bits
    for (int i = 0; i < 64; i++) begin
      fv = 1'b1; fb = (i == 0) ? 32'h1 : 32'h0;
      @(posedge clk_in); #1;
    end
    fv = 1'b0;
    chk("full_ready", fready, 1'b1);
    chk("full_valid_t1", fnvalid, 1'b0);
    @(posedge clk_in); #1;
    chk("full_valid_t2", fnvalid, 1'b1);
    ones = 0; lastcnt = 0; lastidx = -1; first = 1'b0;
    for (int i = 0; i < 2048; i++) begin
      if (i == 0) first = fnbit;
      ones += int'(fnbit);
      if (flast) begin lastcnt++; lastidx = i; end
      fc = 1'b1;
      @(posedge clk_in); #1;
      fc = 1'b0;
    end
    chk("full_first", first, 1'b1);
    chk("full_ones", ones, 1);
    chk("full_lastcnt", lastcnt, 1);
    chk("full_lastidx", lastidx, 2047);
    chk("full_done", fdone, 1'b1);
    chk("full_valid_fall", fnvalid, 1'b0);
    chk("full_uf", fuf, 1'b0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
